mux_scan_n: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer, successor to the fixed 4-bit 4-to-1 mux used in the display and datapath labs. It has two modes. Direct mode selects a channel from an external select input. Scan mode steps through the channels round-robin, holding each one for a programmable number of clocks, as needed for time-multiplexed seven-segment/LED drivers. The output and the active channel index are registered. A one-cycle strobe marks every channel change.

---
 rtl/mux_scan_n.sv | 98 +++++++++
 tb/tb_mux_scan_n.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - N-channel W-bit registered mux with direct select and round-robin scan
//
// Purpose: selects one of N W-bit channels into a registered output. In direct
// mode the channel comes from s; in scan mode the channel steps round-robin,
// each channel held DIV clocks, for time-multiplexed display drivers.
//
// Ports:
//   clk      in   1     rising-edge clock
//   rst      in   1     synchronous active-high reset
//   mode     in   1     0 = direct select, 1 = auto-scan
//   hold     in   1     scan mode: 1 freezes the tick counter and channel
//   s        in   SW    direct-mode channel select (values >= N ignored)
//   din      in   N*W   channel k at din[k*W +: W]
//   o        out  W     registered selected data
//   sel_out  out  SW    registered active channel index
//   strobe   out  1     one-cycle pulse whenever sel_out changes
module mux_scan_n #(
  parameter int W   = 4,
  parameter int N   = 4,
  parameter int SW  = 2,
  parameter int DIV = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic           hold,
  input  logic [SW-1:0]  s,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   o,
  output logic [SW-1:0]  sel_out,
  output logic           strobe
);

  // The tick counter needs at least one bit even when DIV == 1.
  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(N - 1);
  // One extra bit so N == 2**SW is representable for the range check.
  localparam logic [SW:0]   N_EXT    = (SW + 1)'(N);

  logic [SW-1:0] sel;
  logic [SW-1:0] sel_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          mode_q;
  logic [W-1:0]  o_nxt;

  always_comb begin
    sel_nxt = sel;
    cnt_nxt = cnt;
    if (!mode) begin
      // Direct select; an out-of-range s keeps the current channel.
      cnt_nxt = '0;
      if ({1'b0, s} < N_EXT) begin
        sel_nxt = s;
      end
    end else if (mode != mode_q) begin
      // Entering scan: restart the tick count, never advance on the switch edge.
      cnt_nxt = '0;
    end else if (!hold) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt = '0;
        sel_nxt = (sel == SEL_LAST) ? '0 : sel + SW'(1);
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // Output follows the channel chosen for the next cycle, so latency is one clock.
  always_comb begin
    o_nxt = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_nxt == SW'(k)) begin
        o_nxt = din[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel    <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
      o      <= '0;
      strobe <= 1'b0;
    end else begin
      sel    <= sel_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode;
      o      <= o_nxt;
      strobe <= (sel_nxt != sel);
    end
  end

  assign sel_out = sel;

endmodule

// File: tb/tb_mux_scan_n.sv
// tb/tb_mux_scan_n.sv - scoreboard bench for mux_scan_n (4x4 DIV=4 and 5x8 DIV=1)
module tb_mux_scan_n;

  typedef struct packed {
    logic [7:0] o;
    logic [2:0] sel;
    logic       stb;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: W=4, N=4, DIV=4
  logic        rst_a, mode_a, hold_a;
  logic [1:0]  s_a;
  logic [15:0] din_a;
  logic [3:0]  o_a;
  logic [1:0]  sel_a;
  logic        strobe_a;

  // Instance B: W=8, N=5, DIV=1
  logic        rst_b, mode_b, hold_b;
  logic [2:0]  s_b;
  logic [39:0] din_b;
  logic [7:0]  o_b;
  logic [2:0]  sel_b;
  logic        strobe_b;

  mux_scan_n #(.W(4), .N(4), .SW(2), .DIV(4)) dut_a (
    .clk(clk), .rst(rst_a), .mode(mode_a), .hold(hold_a), .s(s_a), .din(din_a),
    .o(o_a), .sel_out(sel_a), .strobe(strobe_a)
  );

  mux_scan_n #(.W(8), .N(5), .SW(3), .DIV(1)) dut_b (
    .clk(clk), .rst(rst_b), .mode(mode_b), .hold(hold_b), .s(s_b), .din(din_b),
    .o(o_b), .sel_out(sel_b), .strobe(strobe_b)
  );

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int   ma_sel = 0, ma_cnt = 0;
  logic ma_mq = 1'b0;
  int   mb_sel = 0, mb_cnt = 0;
  logic mb_mq = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one clock edge, written from the block description.
  task automatic model_step(input int n, input int div, input int w,
                            input logic r, input logic m, input logic h, input int sv,
                            input logic [39:0] din,
                            inout int sel, inout int cnt, inout logic mq,
                            output logic [7:0] o, output logic stb);
    int nxt;
    int cn;
    if (r) begin
      sel = 0; cnt = 0; mq = 1'b0; o = 8'h00; stb = 1'b0;
      return;
    end
    nxt = sel;
    cn  = cnt;
    if (!m) begin
      cn = 0;
      if (sv < n) nxt = sv;
    end else if (m != mq) begin
      cn = 0;
    end else if (!h) begin
      if (cnt == div - 1) begin
        cn  = 0;
        nxt = (sel == n - 1) ? 0 : sel + 1;
      end else begin
        cn = cnt + 1;
      end
    end
    stb = (nxt != sel);
    o   = 8'((din >> (nxt * w)) & ((40'd1 << w) - 40'd1));
    sel = nxt;
    cnt = cn;
    mq  = m;
  endtask

  task automatic cyc_a(input logic r, input logic m, input logic h, input logic [1:0] sv);
    exp_t e;
    exp_t g;
    logic [7:0] eo;
    logic es;
    rst_a = r; mode_a = m; hold_a = h; s_a = sv;
    model_step(4, 4, 4, r, m, h, int'(sv), {24'b0, din_a}, ma_sel, ma_cnt, ma_mq, eo, es);
    e.o = eo; e.sel = 3'(ma_sel); e.stb = es;
    qa.push_back(e);
    @(posedge clk); #1;
    g = qa.pop_front();
    check("a_o", 32'(o_a), 32'(g.o));
    check("a_sel", 32'(sel_a), 32'(g.sel));
    check("a_strobe", 32'(strobe_a), 32'(g.stb));
  endtask

  task automatic cyc_b(input logic r, input logic m, input logic h, input logic [2:0] sv);
    exp_t e;
    exp_t g;
    logic [7:0] eo;
    logic es;
    rst_b = r; mode_b = m; hold_b = h; s_b = sv;
    model_step(5, 1, 8, r, m, h, int'(sv), din_b, mb_sel, mb_cnt, mb_mq, eo, es);
    e.o = eo; e.sel = 3'(mb_sel); e.stb = es;
    qb.push_back(e);
    @(posedge clk); #1;
    g = qb.pop_front();
    check("b_o", 32'(o_b), 32'(g.o));
    check("b_sel", 32'(sel_b), 32'(g.sel));
    check("b_strobe", 32'(strobe_b), 32'(g.stb));
  endtask

  initial begin
    logic m;
    rst_a = 1'b1; mode_a = 1'b0; hold_a = 1'b0; s_a = 2'd0; din_a = 16'hA5A5;
    rst_b = 1'b1; mode_b = 1'b0; hold_b = 1'b0; s_b = 3'd0; din_b = 40'h1413121110;

    // Reset and direct mode with alternating 5/A data
    cyc_a(1'b1, 1'b0, 1'b0, 2'd0);
    check("t1_rst_o", 32'(o_a), 32'h0);
    check("t1_rst_sel", 32'(sel_a), 32'h0);
    check("t1_rst_strobe", 32'(strobe_a), 32'h0);
    for (int sv = 0; sv < 4; sv++) begin
      for (int j = 0; j < 5; j++) begin
        cyc_a(1'b0, 1'b0, 1'b0, 2'(sv));
        if (j == 0) begin
          check("t1_o", 32'(o_a), (sv % 2 == 1) ? 32'hA : 32'h5);
          check("t1_sel", 32'(sel_a), 32'(sv));
          check("t1_strobe", 32'(strobe_a), 32'(sv != 0));
        end else begin
          check("t1_strobe_quiet", 32'(strobe_a), 32'h0);
        end
      end
    end

    // Scan with DIV=4 across a full rotation, including wrap 3->0
    din_a = 16'h3210;
    cyc_a(1'b0, 1'b0, 1'b0, 2'd0);
    cyc_a(1'b0, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k <= 16; k++) begin
      cyc_a(1'b0, 1'b1, 1'b0, 2'd0);
      check("t2_sel", 32'(sel_a), 32'((k / 4) % 4));
      check("t2_o", 32'(o_a), 32'((k / 4) % 4));
      check("t2_strobe", 32'(strobe_a), 32'(k > 0 && k % 4 == 0));
    end

    // Hold mid-channel 2; count resumes from the frozen value
    for (int k = 17; k <= 25; k++) cyc_a(1'b0, 1'b1, 1'b0, 2'd0);
    check("t3_pre_sel", 32'(sel_a), 32'd2);
    for (int k = 0; k < 10; k++) begin
      cyc_a(1'b0, 1'b1, 1'b1, 2'd0);
      check("t3_hold_sel", 32'(sel_a), 32'd2);
      check("t3_hold_strobe", 32'(strobe_a), 32'h0);
    end
    cyc_a(1'b0, 1'b1, 1'b0, 2'd0);
    check("t3_rel1_sel", 32'(sel_a), 32'd2);
    cyc_a(1'b0, 1'b1, 1'b0, 2'd0);
    check("t3_rel2_sel", 32'(sel_a), 32'd2);
    cyc_a(1'b0, 1'b1, 1'b0, 2'd0);
    check("t3_rel3_sel", 32'(sel_a), 32'd3);
    check("t3_rel3_strobe", 32'(strobe_a), 32'h1);

    // Mode change 1->0 then 0->1
    cyc_a(1'b0, 1'b0, 1'b0, 2'd1);
    check("t4_direct_sel", 32'(sel_a), 32'd1);
    check("t4_direct_strobe", 32'(strobe_a), 32'h1);
    check("t4_direct_o", 32'(o_a), 32'd1);
    cyc_a(1'b0, 1'b0, 1'b0, 2'd1);
    check("t4_same_s_strobe", 32'(strobe_a), 32'h0);
    for (int k = 0; k <= 4; k++) begin
      cyc_a(1'b0, 1'b1, 1'b0, 2'd1);
      check("t4_scan_sel", 32'(sel_a), (k < 4) ? 32'd1 : 32'd2);
      check("t4_scan_strobe", 32'(strobe_a), 32'(k == 4));
    end

    // Reset during scan at cycle 2 of channel 1
    for (int k = 0; k < 13; k++) cyc_a(1'b0, 1'b1, 1'b0, 2'd0);
    check("t6_pre_sel", 32'(sel_a), 32'd1);
    cyc_a(1'b1, 1'b1, 1'b0, 2'd0);
    check("t6_rst_o", 32'(o_a), 32'h0);
    check("t6_rst_sel", 32'(sel_a), 32'h0);
    check("t6_rst_strobe", 32'(strobe_a), 32'h0);
    for (int k = 0; k <= 4; k++) begin
      cyc_a(1'b0, 1'b1, 1'b0, 2'd0);
      check("t6_restart_sel", 32'(sel_a), (k < 4) ? 32'd0 : 32'd1);
    end

    // Random traffic on instance A, scoreboard only
    m = 1'b1;
    for (int k = 0; k < 120; k++) begin
      din_a = 16'($urandom);
      if ($urandom_range(0, 9) == 0) m = ~m;
      cyc_a(1'($urandom_range(0, 29) == 0), m, 1'($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)));
    end

    // Instance B: DIV=1 scan, N=5 wrap, out-of-range select
    cyc_b(1'b1, 1'b0, 1'b0, 3'd0);
    check("t5_rst_o", 32'(o_b), 32'h0);
    for (int k = 0; k <= 5; k++) begin
      cyc_b(1'b0, 1'b1, 1'b0, 3'd0);
      check("t5_scan_sel", 32'(sel_b), 32'(k % 5));
      check("t5_scan_o", 32'(o_b), 32'h10 + 32'(k % 5));
      check("t5_scan_strobe", 32'(strobe_b), 32'(k > 0));
    end
    cyc_b(1'b0, 1'b0, 1'b0, 3'd2);
    cyc_b(1'b0, 1'b0, 1'b0, 3'd2);
    for (int sv = 5; sv <= 7; sv++) begin
      cyc_b(1'b0, 1'b0, 1'b0, 3'(sv));
      check("t5_oor_sel", 32'(sel_b), 32'd2);
      check("t5_oor_o", 32'(o_b), 32'h12);
      check("t5_oor_strobe", 32'(strobe_b), 32'h0);
    end

    m = 1'b0;
    for (int k = 0; k < 100; k++) begin
      din_b = {8'($urandom), 32'($urandom)};
      if ($urandom_range(0, 7) == 0) m = ~m;
      cyc_b(1'($urandom_range(0, 29) == 0), m, 1'($urandom_range(0, 3) == 0),
            3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
